// File: rtl/sfp_port_mgr.sv
// SFP cage manager: synchronises and debounces cage status pins, sequences TX_DISABLE
// per channel, latches transmitter faults and drives one status LED per cage.
module sfp_port_mgr #(
    parameter int CHANNELS          = 2,
    parameter int DEBOUNCE_CYCLES   = 1000,
    parameter int TXEN_DELAY_CYCLES = 10_000_000,
    parameter int BLINK_HALF_CYCLES = 25_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CHANNELS-1:0]     sfp_mod_abs,
    input  logic [CHANNELS-1:0]     sfp_rxlos,
    input  logic [CHANNELS-1:0]     sfp_txflt,
    input  logic [CHANNELS-1:0]     tx_enable_req,
    input  logic [CHANNELS-1:0]     fault_clr,
    output logic [CHANNELS-1:0]     sfp_tx_dis,
    output logic [CHANNELS-1:0]     present,
    output logic [CHANNELS-1:0]     link_ok,
    output logic [CHANNELS-1:0]     fault_latched,
    output logic [2*CHANNELS-1:0]   state,
    output logic [CHANNELS-1:0]     led
);

    localparam int NIN       = 3 * CHANNELS;
    localparam int DW        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW        = $clog2(TXEN_DELAY_CYCLES + 1);
    localparam int BW        = $clog2(BLINK_HALF_CYCLES + 1);
    localparam int FAST_HALF = (BLINK_HALF_CYCLES / 4 > 1) ? (BLINK_HALF_CYCLES / 4) : 1;

    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] TXEN_MAX = TW'(TXEN_DELAY_CYCLES);
    localparam logic [BW-1:0] SLOW_TOP = BW'(BLINK_HALF_CYCLES - 1);
    localparam logic [BW-1:0] FAST_TOP = BW'(FAST_HALF - 1);
    // Input vector layout is {txflt, rxlos, mod_abs}; idle levels are no fault, loss, absent.
    localparam logic [NIN-1:0] IN_RST = {{CHANNELS{1'b0}}, {CHANNELS{1'b1}}, {CHANNELS{1'b1}}};

    typedef enum logic [1:0] {
        ST_ABSENT = 2'd0,
        ST_INIT   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_FAULT  = 2'd3
    } st_e;

    logic [NIN-1:0] raw_s, sync1_q, sync2_q, deb_q, deb_d;
    logic [DW-1:0]  cnt_q [NIN];
    logic [DW-1:0]  cnt_d [NIN];
    logic [CHANNELS-1:0] mod_abs_s, rxlos_s, txflt_s;

    logic [BW-1:0] slow_cnt_q, slow_cnt_d, fast_cnt_q, fast_cnt_d;
    logic          slow_ph_q, slow_ph_d, fast_ph_q, fast_ph_d;

    st_e           st_q  [CHANNELS];
    st_e           st_d  [CHANNELS];
    logic [TW-1:0] tmr_q [CHANNELS];
    logic [TW-1:0] tmr_d [CHANNELS];

    logic [CHANNELS-1:0] tx_dis_q, tx_dis_d, present_q, present_d, link_q, link_d;
    logic [CHANNELS-1:0] flt_q, flt_d, led_q, led_d;

    assign raw_s     = {sfp_txflt, sfp_rxlos, sfp_mod_abs};
    assign mod_abs_s = deb_q[CHANNELS-1:0];
    assign rxlos_s   = deb_q[2*CHANNELS-1:CHANNELS];
    assign txflt_s   = deb_q[3*CHANNELS-1:2*CHANNELS];

    // Debounce next state: a level must differ for DEBOUNCE_CYCLES+1 consecutive edges.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NIN; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DEB_MAX) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + DW'(1);
            end
        end
    end

    // Synchroniser and debouncer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= IN_RST;
            sync2_q <= IN_RST;
            deb_q   <= IN_RST;
            for (int i = 0; i < NIN; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= raw_s;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            for (int i = 0; i < NIN; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Shared blink divider next state.
    always_comb begin
        slow_cnt_d = slow_cnt_q + BW'(1);
        slow_ph_d  = slow_ph_q;
        fast_cnt_d = fast_cnt_q + BW'(1);
        fast_ph_d  = fast_ph_q;
        if (slow_cnt_q == SLOW_TOP) begin
            slow_cnt_d = '0;
            slow_ph_d  = ~slow_ph_q;
        end else begin
            slow_ph_d  = slow_ph_q;
        end
        if (fast_cnt_q == FAST_TOP) begin
            fast_cnt_d = '0;
            fast_ph_d  = ~fast_ph_q;
        end else begin
            fast_ph_d  = fast_ph_q;
        end
    end

    // FSM state and timer registers, plus blink divider.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                st_q[c]  <= ST_ABSENT;
                tmr_q[c] <= '0;
            end
            slow_cnt_q <= '0;
            slow_ph_q  <= 1'b0;
            fast_cnt_q <= '0;
            fast_ph_q  <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                st_q[c]  <= st_d[c];
                tmr_q[c] <= tmr_d[c];
            end
            slow_cnt_q <= slow_cnt_d;
            slow_ph_q  <= slow_ph_d;
            fast_cnt_q <= fast_cnt_d;
            fast_ph_q  <= fast_ph_d;
        end
    end

    // Per-channel next state; module absence overrides everything.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            st_d[c]  = st_q[c];
            tmr_d[c] = tmr_q[c];
            if (mod_abs_s[c]) begin
                st_d[c]  = ST_ABSENT;
                tmr_d[c] = '0;
            end else begin
                case (st_q[c])
                    ST_ABSENT: begin
                        st_d[c]  = ST_INIT;
                        tmr_d[c] = TXEN_MAX;
                    end
                    ST_INIT: begin
                        if (tmr_q[c] != '0) begin
                            tmr_d[c] = tmr_q[c] - TW'(1);
                        end else if (tx_enable_req[c]) begin
                            st_d[c] = ST_ACTIVE;
                        end else begin
                            st_d[c] = ST_INIT;
                        end
                    end
                    ST_ACTIVE: begin
                        if (txflt_s[c]) begin
                            st_d[c] = ST_FAULT;
                        end else if (!tx_enable_req[c]) begin
                            st_d[c]  = ST_INIT;
                            tmr_d[c] = '0;
                        end else begin
                            st_d[c] = ST_ACTIVE;
                        end
                    end
                    ST_FAULT: begin
                        if (fault_clr[c] && !txflt_s[c]) begin
                            st_d[c]  = ST_INIT;
                            tmr_d[c] = TXEN_MAX;
                        end else begin
                            st_d[c] = ST_FAULT;
                        end
                    end
                    default: begin
                        st_d[c]  = ST_ABSENT;
                        tmr_d[c] = '0;
                    end
                endcase
            end
        end
    end

    // Output next values, derived from next state so outputs align with the state register.
    always_comb begin
        present_d = ~mod_abs_s;
        link_d    = ~mod_abs_s & ~rxlos_s;
        tx_dis_d  = '1;
        flt_d     = flt_q;
        led_d     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            tx_dis_d[c] = (st_d[c] != ST_ACTIVE);
            if (st_q[c] == ST_ACTIVE && st_d[c] == ST_FAULT) begin
                flt_d[c] = 1'b1;
            end else if (fault_clr[c]) begin
                flt_d[c] = 1'b0;
            end else begin
                flt_d[c] = flt_q[c];
            end
            case (st_d[c])
                ST_ABSENT: led_d[c] = 1'b0;
                ST_INIT:   led_d[c] = slow_ph_d;
                ST_ACTIVE: led_d[c] = link_d[c] ? 1'b1 : slow_ph_d;
                ST_FAULT:  led_d[c] = fast_ph_d;
                default:   led_d[c] = 1'b0;
            endcase
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_dis_q  <= '1;
            present_q <= '0;
            link_q    <= '0;
            flt_q     <= '0;
            led_q     <= '0;
        end else begin
            tx_dis_q  <= tx_dis_d;
            present_q <= present_d;
            link_q    <= link_d;
            flt_q     <= flt_d;
            led_q     <= led_d;
        end
    end

    // Pack the per-channel state register onto the state port.
    always_comb begin
        state = '0;
        for (int c = 0; c < CHANNELS; c++) state[2*c +: 2] = st_q[c];
    end

    assign sfp_tx_dis    = tx_dis_q;
    assign present       = present_q;
    assign link_ok       = link_q;
    assign fault_latched = flt_q;
    assign led           = led_q;

endmodule

// File: tb/tb_sfp_port_mgr.sv
// Directed bench for sfp_port_mgr with CHANNELS=2, DEBOUNCE=4, TXEN_DELAY=16, BLINK_HALF=8.
module tb_sfp_port_mgr;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sfp_mod_abs, sfp_rxlos, sfp_txflt, tx_enable_req, fault_clr;
    logic [1:0] sfp_tx_dis, present, link_ok, fault_latched, led;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;
    int period;

    sfp_port_mgr #(
        .CHANNELS(2), .DEBOUNCE_CYCLES(4), .TXEN_DELAY_CYCLES(16), .BLINK_HALF_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .sfp_mod_abs(sfp_mod_abs), .sfp_rxlos(sfp_rxlos), .sfp_txflt(sfp_txflt),
        .tx_enable_req(tx_enable_req), .fault_clr(fault_clr),
        .sfp_tx_dis(sfp_tx_dis), .present(present), .link_ok(link_ok),
        .fault_latched(fault_latched), .state(state), .led(led)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Cycles between two consecutive transitions of led[idx]; 0 when they do not occur within the window.
    task automatic measure_period(input int idx, output int p);
        logic v;
        int   n;
        p = 0;
        v = led[idx];
        n = 0;
        while (led[idx] == v && n < 40) begin tick(1); n++; end
        if (led[idx] != v) begin
            v = led[idx];
            n = 0;
            while (led[idx] == v && n < 40) begin tick(1); n++; end
            if (led[idx] != v) p = n;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_txdis"},  32'(sfp_tx_dis),    32'h3);
        check_eq({tag, "_pres"},   32'(present),       32'h0);
        check_eq({tag, "_link"},   32'(link_ok),       32'h0);
        check_eq({tag, "_flt"},    32'(fault_latched), 32'h0);
        check_eq({tag, "_state"},  32'(state),         32'h0);
        check_eq({tag, "_led"},    32'(led),           32'h0);
    endtask

    initial begin
        rst = 1'b1;
        sfp_mod_abs = 2'b11; sfp_rxlos = 2'b11; sfp_txflt = 2'b00;
        tx_enable_req = 2'b00; fault_clr = 2'b00;
        tick(3);
        check_reset_outputs("rst");
        rst = 1'b0;
        tick(5);
        check_eq("idle_state", 32'(state), 32'h0);

        // Insertion on ch0: present at k+7, ACTIVE 17 edges after INIT entry
        sfp_mod_abs[0] = 1'b0; tx_enable_req = 2'b01;
        tick(7);
        check_eq("ins_pres_early", 32'(present), 32'h0);
        tick(1);
        check_eq("ins_pres",   32'(present), 32'h1);
        check_eq("ins_state",  32'(state),   32'h1);
        check_eq("ins_txdis",  32'(sfp_tx_dis), 32'h3);
        tick(16);
        check_eq("init_hold",  32'(state),   32'h1);
        tick(1);
        check_eq("act_state",  32'(state),   32'h2);
        check_eq("act_txdis",  32'(sfp_tx_dis), 32'h2);

        // ACTIVE without link: slow blink
        measure_period(0, period);
        check_eq("slow_period", 32'(period), 32'd8);

        // Link up: solid LED
        sfp_rxlos[0] = 1'b0;
        tick(8);
        check_eq("link_ok", 32'(link_ok), 32'h1);
        check_eq("led_on",  32'(led[0]),  32'h1);
        tick(10);
        check_eq("led_solid", 32'(led[0]), 32'h1);

        // Enable drop returns to INIT with expired timer, re-enable is immediate
        tx_enable_req[0] = 1'b0;
        tick(1);
        check_eq("dis_state", 32'(state), 32'h1);
        check_eq("dis_txdis", 32'(sfp_tx_dis), 32'h3);
        tx_enable_req[0] = 1'b1;
        tick(1);
        check_eq("reen_state", 32'(state), 32'h2);

        // Debounce on ch1: 3-cycle glitch rejected, 5-cycle pulse passes
        sfp_mod_abs[1] = 1'b0; tick(3); sfp_mod_abs[1] = 1'b1;
        tick(10);
        check_eq("glitch_pres",  32'(present[1]), 32'h0);
        check_eq("glitch_state", 32'(state[3:2]), 32'h0);
        sfp_mod_abs[1] = 1'b0; tick(5); sfp_mod_abs[1] = 1'b1;
        tick(3);
        check_eq("pulse_rise", 32'(present[1]), 32'h1);
        check_eq("pulse_init", 32'(state[3:2]), 32'h1);
        tick(5);
        check_eq("pulse_fall", 32'(present[1]), 32'h0);
        check_eq("pulse_abs",  32'(state[3:2]), 32'h0);

        // Fault on ch0
        sfp_txflt[0] = 1'b1;
        tick(8);
        check_eq("flt_state", 32'(state[1:0]), 32'h3);
        check_eq("flt_txdis", 32'(sfp_tx_dis[0]), 32'h1);
        check_eq("flt_latch", 32'(fault_latched[0]), 32'h1);
        measure_period(0, period);
        check_eq("fast_period", 32'(period), 32'd2);
        fault_clr[0] = 1'b1; tick(1); fault_clr[0] = 1'b0;
        check_eq("clr_ignored", 32'(state[1:0]), 32'h3);
        sfp_txflt[0] = 1'b0;
        tick(8);
        fault_clr[0] = 1'b1; tick(1); fault_clr[0] = 1'b0;
        check_eq("clr_init",  32'(state[1:0]), 32'h1);
        check_eq("clr_txdis", 32'(sfp_tx_dis[0]), 32'h1);
        tick(16);
        check_eq("clr_hold",  32'(state[1:0]), 32'h1);
        tick(1);
        check_eq("clr_active", 32'(state[1:0]), 32'h2);

        // Fault then removal: latch persists in ABSENT until cleared
        sfp_txflt[0] = 1'b1;
        tick(8);
        check_eq("flt2_latch", 32'(fault_latched[0]), 32'h1);
        sfp_txflt[0] = 1'b0; sfp_mod_abs[0] = 1'b1;
        tick(8);
        check_eq("rmf_state", 32'(state[1:0]), 32'h0);
        check_eq("rmf_txdis", 32'(sfp_tx_dis[0]), 32'h1);
        check_eq("rmf_led",   32'(led[0]), 32'h0);
        check_eq("rmf_latch", 32'(fault_latched[0]), 32'h1);
        check_eq("rmf_link",  32'(link_ok[0]), 32'h0);
        fault_clr[0] = 1'b1; tick(1); fault_clr[0] = 1'b0;
        check_eq("abs_clr", 32'(fault_latched[0]), 32'h0);

        // Removal during INIT
        sfp_mod_abs[0] = 1'b0;
        tick(8);
        check_eq("ri_init", 32'(state[1:0]), 32'h1);
        sfp_mod_abs[0] = 1'b1;
        tick(8);
        check_eq("ri_abs", 32'(state[1:0]), 32'h0);
        check_eq("ri_led", 32'(led[0]), 32'h0);

        // Reset while ACTIVE
        sfp_mod_abs[0] = 1'b0;
        tick(25);
        check_eq("pre_rst_active", 32'(state[1:0]), 32'h2);
        rst = 1'b1;
        tick(1);
        check_reset_outputs("mid_rst");
        rst = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
